nnlut_coef_loader: RTL and testbench

//  Write side of the NN-LUT coefficient tables. Accepts a word stream (header, 16 breakpoints, 16 k, 16 b)

---
 rtl/nnlut_pkg.sv | 33 +++
 rtl/nnlut_coef_bank.sv | 51 +++++
 rtl/nnlut_coef_loader.sv | 188 ++++++++++++++++++
 tb/tb_nnlut_coef_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnlut_pkg.sv
// Shared types and default-table values for the NN-LUT coefficient loader.
package nnlut_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BP     = 3'd1,
    ST_K      = 3'd2,
    ST_B      = 3'd3,
    ST_CSUM   = 3'd4,
    ST_COMMIT = 3'd5
  } nnlut_state_e;

  typedef enum logic [1:0] {
    TBL_BP = 2'd0,
    TBL_K  = 2'd1,
    TBL_B  = 2'd2
  } nnlut_tbl_e;

  localparam logic [15:0] NNLUT_HDR_MAGIC = 16'h4C54;

  function automatic logic [31:0] bp_default(input int i);
    return 32'(2 * (i + 1));
  endfunction

  function automatic logic [31:0] k_default(input int i);
    return 32'(i + 1);
  endfunction

  function automatic logic [31:0] b_default(input int i);
    return 32'(i + 1);
  endfunction

endpackage

// File: rtl/nnlut_coef_bank.sv
// Shadow/active register pair for one coefficient table; the active copy
// only changes on reset (defaults) or on a whole-table commit strobe.
module nnlut_coef_bank
  import nnlut_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         NUM   = 16,
  parameter nnlut_tbl_e KIND  = TBL_BP
) (
  input  logic                 clk_p,
  input  logic                 rst_p,
  input  logic [NUM-1:0]       i_we,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic                 i_commit,
  output logic [NUM*WIDTH-1:0] o_flat
);

  logic [WIDTH-1:0] r_shadow [NUM];
  logic [WIDTH-1:0] r_active [NUM];

  function automatic logic [WIDTH-1:0] def_val(input int i);
    logic [31:0] v;
    case (KIND)
      TBL_BP:  v = bp_default(i);
      TBL_K:   v = k_default(i);
      TBL_B:   v = b_default(i);
      default: v = 32'd0;
    endcase
    return v[WIDTH-1:0];
  endfunction

  // shadow takes stream writes; active copies the whole shadow on commit
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      for (int i = 0; i < NUM; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= def_val(i);
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (i_we[i]) r_shadow[i] <= i_wdata;
        if (i_commit) r_active[i] <= r_shadow[i];
      end
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_flat
    assign o_flat[g*WIDTH +: WIDTH] = r_active[g];
  end

endmodule

// File: rtl/nnlut_coef_loader.sv
// NN-LUT coefficient loader: header/bp/k/b word stream into shadow banks, atomic commit.
// Optional trailing checksum word when NNLUT_LOAD_CHECKSUM_EN is defined.
module nnlut_coef_loader
  import nnlut_pkg::*;
#(
  parameter int x_WIDTH    = 8,
  parameter int k_WIDTH    = 32,
  parameter int b_WIDTH    = 32,
  parameter int bp_NUM     = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic                        clk_p,
  input  logic                        rst_p,
  input  logic [WORD_WIDTH-1:0]       wr_data,
  input  logic                        wr_valid_n,
  output logic                        wr_ready_n,
  output logic [bp_NUM*x_WIDTH-1:0]   bp_flat,
  output logic [bp_NUM*k_WIDTH-1:0]   k_flat,
  output logic [bp_NUM*b_WIDTH-1:0]   b_flat,
  output logic                        tbl_update_p,
  output logic                        load_err_p,
  output logic                        busy
);

  localparam int               IDX_W     = (bp_NUM > 1) ? $clog2(bp_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(bp_NUM - 1);
  localparam logic [7:0]       HDR_COUNT = 8'(bp_NUM);

  nnlut_state_e       r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ready_n;
  logic               r_update;
  logic               r_err;
  logic               r_busy;
  logic [x_WIDTH-1:0] r_last_bp;

  logic               w_xfer;
  logic               w_hdr_ok;
  logic               w_bp_ok;
  logic               w_last;
  logic               w_commit;
  logic [IDX_W-1:0]   w_idx_next;
  logic [bp_NUM-1:0]  w_we_onehot;
  logic [bp_NUM-1:0]  w_we_bp;
  logic [bp_NUM-1:0]  w_we_k;
  logic [bp_NUM-1:0]  w_we_b;

  // transfer decode, breakpoint ordering check and per-entry write enables
  always_comb begin
    w_xfer      = !wr_valid_n && !r_ready_n;
    w_hdr_ok    = (wr_data[31:16] == NNLUT_HDR_MAGIC) && (wr_data[7:0] == HDR_COUNT);
    w_bp_ok     = (r_idx == '0) || ($signed(wr_data[x_WIDTH-1:0]) > $signed(r_last_bp));
    w_last      = (r_idx == IDX_LAST);
    w_idx_next  = w_last ? '0 : r_idx + 1'b1;
    w_commit    = (r_state == ST_COMMIT);
    w_we_onehot = '0;
    w_we_onehot[r_idx] = w_xfer;
    w_we_bp     = ((r_state == ST_BP) && w_bp_ok) ? w_we_onehot : '0;
    w_we_k      = (r_state == ST_K) ? w_we_onehot : '0;
    w_we_b      = (r_state == ST_B) ? w_we_onehot : '0;
  end

`ifdef NNLUT_LOAD_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_csum;

  // running modular sum of the payload words of the current load
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      r_csum <= '0;
    end else if (r_state == ST_IDLE) begin
      r_csum <= '0;
    end else if (w_xfer && ((r_state == ST_BP) || (r_state == ST_K) || (r_state == ST_B))) begin
      r_csum <= r_csum + wr_data;
    end else begin
      r_csum <= r_csum;
    end
  end
`endif

  // load sequencer; an error always drops back to IDLE without committing
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ready_n <= 1'b0;
      r_update  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_last_bp <= '0;
    end else begin
      r_update <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_hdr_ok) begin
              r_state <= ST_BP;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_BP: begin
          if (w_xfer) begin
            if (!w_bp_ok) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_idx   <= '0;
            end else begin
              r_last_bp <= wr_data[x_WIDTH-1:0];
              r_idx     <= w_idx_next;
              if (w_last) r_state <= ST_K;
            end
          end
        end
        ST_K: begin
          if (w_xfer) begin
            r_idx <= w_idx_next;
            if (w_last) r_state <= ST_B;
          end
        end
        ST_B: begin
          if (w_xfer) begin
            r_idx <= w_idx_next;
            if (w_last) begin
`ifdef NNLUT_LOAD_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state   <= ST_COMMIT;
              r_ready_n <= 1'b1;
`endif
            end
          end
        end
`ifdef NNLUT_LOAD_CHECKSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            if (wr_data == r_csum) begin
              r_state   <= ST_COMMIT;
              r_ready_n <= 1'b1;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
`endif
        ST_COMMIT: begin
          r_state   <= ST_IDLE;
          r_ready_n <= 1'b0;
          r_update  <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ready_n <= 1'b0;
          r_busy    <= 1'b0;
          r_idx     <= '0;
        end
      endcase
    end
  end

  nnlut_coef_bank #(.WIDTH(x_WIDTH), .NUM(bp_NUM), .KIND(TBL_BP)) u_bank_bp (
    .clk_p(clk_p), .rst_p(rst_p), .i_we(w_we_bp), .i_wdata(wr_data[x_WIDTH-1:0]),
    .i_commit(w_commit), .o_flat(bp_flat)
  );

  nnlut_coef_bank #(.WIDTH(k_WIDTH), .NUM(bp_NUM), .KIND(TBL_K)) u_bank_k (
    .clk_p(clk_p), .rst_p(rst_p), .i_we(w_we_k), .i_wdata(wr_data[k_WIDTH-1:0]),
    .i_commit(w_commit), .o_flat(k_flat)
  );

  nnlut_coef_bank #(.WIDTH(b_WIDTH), .NUM(bp_NUM), .KIND(TBL_B)) u_bank_b (
    .clk_p(clk_p), .rst_p(rst_p), .i_we(w_we_b), .i_wdata(wr_data[b_WIDTH-1:0]),
    .i_commit(w_commit), .o_flat(b_flat)
  );

  assign wr_ready_n   = r_ready_n;
  assign tbl_update_p = r_update;
  assign load_err_p   = r_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_nnlut_coef_loader.sv
// Self-checking bench for nnlut_coef_loader: header vector table, directed loads,
// randomized loads with gaps and ordering faults against a table-level model.
module tb_nnlut_coef_loader;

  localparam int XW = 8;
  localparam int KW = 32;
  localparam int BW = 32;
  localparam int N  = 16;
  localparam int WW = 32;
  localparam logic [31:0] HDR = 32'h4C54_0010;

  logic            clk_p = 1'b0;
  logic            rst_p = 1'b1;
  logic [WW-1:0]   wr_data = '0;
  logic            wr_valid_n = 1'b1;
  logic            wr_ready_n;
  logic [N*XW-1:0] bp_flat;
  logic [N*KW-1:0] k_flat;
  logic [N*BW-1:0] b_flat;
  logic            tbl_update_p;
  logic            load_err_p;
  logic            busy;

  always #5 clk_p = ~clk_p;

  nnlut_coef_loader dut (
    .clk_p(clk_p), .rst_p(rst_p), .wr_data(wr_data), .wr_valid_n(wr_valid_n),
    .wr_ready_n(wr_ready_n), .bp_flat(bp_flat), .k_flat(k_flat), .b_flat(b_flat),
    .tbl_update_p(tbl_update_p), .load_err_p(load_err_p), .busy(busy)
  );

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  // model: active tables and the next payload to send
  int m_bp[N], m_k[N], m_b[N];
  int p_bp[N], p_k[N], p_b[N];
  int bad_j;

  typedef struct {
    logic [31:0] word;
    logic        exp_err;
    logic        exp_busy;
  } hdr_vec_t;
  hdr_vec_t hv[6];

  always @(negedge clk_p) begin
    if (!rst_p) begin
      if (tbl_update_p) upd_cnt++;
      if (load_err_p) err_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_defaults();
    for (int i = 0; i < N; i++) begin
      m_bp[i] = 2 * (i + 1);
      m_k[i]  = i + 1;
      m_b[i]  = i + 1;
    end
  endtask

  function automatic logic [511:0] exp_flat(input int sel);
    logic [511:0] f;
    logic [31:0]  t;
    f = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == 0) begin
        t = m_bp[i];
        f[i*XW +: XW] = t[XW-1:0];
      end else if (sel == 1) begin
        t = m_k[i];
        f[i*KW +: KW] = t;
      end else begin
        t = m_b[i];
        f[i*BW +: BW] = t;
      end
    end
    return f;
  endfunction

  task automatic check_tables(input string tag);
    check({tag, "_bp_flat"}, bp_flat, exp_flat(0));
    check({tag, "_k_flat"}, k_flat, exp_flat(1));
    check({tag, "_b_flat"}, b_flat, exp_flat(2));
  endtask

  function automatic logic [31:0] pword(input int w);
    if (w < 16) return p_bp[w];
    else if (w < 32) return p_k[w-16];
    else return p_b[w-32];
  endfunction

  task automatic reset_dut();
    rst_p = 1'b1;
    wr_valid_n = 1'b1;
    wr_data = '0;
    repeat (2) @(negedge clk_p);
    rst_p = 1'b0;
    model_defaults();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_p);
  endtask

  // present one word, hold it until accepted, return at the negedge after the transfer
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    wr_data = w;
    wr_valid_n = 1'b0;
    while (wr_ready_n === 1'b1 && n < 10) begin
      @(negedge clk_p);
      n++;
    end
    if (n >= 10) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL ready_timeout: wr_ready_n stuck at %b", wr_ready_n);
    end
    @(negedge clk_p);
    wr_valid_n = 1'b1;
  endtask

  task automatic set_payload_t2();
    for (int i = 0; i < N; i++) begin
      p_bp[i] = -16 + 2 * i;
      p_k[i]  = 100 + i;
      p_b[i]  = -i;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    do r = $urandom; while (r[31:16] == 16'h4C54);
    return r;
  endfunction

  task automatic gen_payload(input bit bad);
    int v;
    v = -128 + int'($urandom_range(10));
    for (int i = 0; i < N; i++) begin
      p_bp[i] = v;
      v += 1 + int'($urandom_range(10));
      p_k[i] = rand_word();
      p_b[i] = rand_word();
    end
    bad_j = -1;
    if (bad) begin
      bad_j = int'($urandom_range(15, 1));
      if (p_bp[bad_j-1] == -128 || $urandom_range(1) == 0) p_bp[bad_j] = p_bp[bad_j-1];
      else p_bp[bad_j] = p_bp[bad_j-1] - 1;
    end
  endtask

  // full load with optional random gaps; expectation derived from table rules
  task automatic do_load(input string tag, input int gap_pct, input int csum_delta, input int chk_err_idx);
    int bad;
    int exp_err;
    bit ok;
    int u0, e0;
    logic [31:0] sum;
    bad = -1;
    for (int i = 1; i < N; i++) if (bad < 0 && p_bp[i] <= p_bp[i-1]) bad = i;
    sum = '0;
    for (int w = 0; w < 3 * N; w++) sum = sum + pword(w);
`ifdef NNLUT_LOAD_CHECKSUM_EN
    ok = (bad < 0) && (csum_delta == 0);
    exp_err = (bad >= 0) ? (3 * N - bad + 1) : ((csum_delta != 0) ? 1 : 0);
`else
    ok = (bad < 0);
    exp_err = (bad >= 0) ? (3 * N - bad) : 0;
`endif
    #1;
    u0 = upd_cnt;
    e0 = err_cnt;
    send_word(HDR);
    check({tag, "_busy_after_hdr"}, busy, 1'b1);
    for (int w = 0; w < 3 * N; w++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle(1 + int'($urandom_range(2)));
      send_word(pword(w));
      if (w == chk_err_idx) begin
        check({tag, "_err_on_bad_bp"}, load_err_p, 1'b1);
        check({tag, "_busy_drop_on_err"}, busy, 1'b0);
      end
    end
`ifdef NNLUT_LOAD_CHECKSUM_EN
    send_word(sum + 32'(csum_delta));
`endif
    if (ok) begin
      check({tag, "_commit_ready_n"}, wr_ready_n, 1'b1);
      check({tag, "_commit_no_upd_yet"}, tbl_update_p, 1'b0);
      @(negedge clk_p);
      check({tag, "_upd_pulse"}, tbl_update_p, 1'b1);
      check({tag, "_busy_after_commit"}, busy, 1'b0);
      m_bp = p_bp;
      m_k  = p_k;
      m_b  = p_b;
    end
    idle(3);
    #1;
    check({tag, "_upd_count"}, 32'(upd_cnt - u0), ok ? 32'd1 : 32'd0);
    check({tag, "_err_count"}, 32'(err_cnt - e0), 32'(exp_err));
    check({tag, "_busy_end"}, busy, 1'b0);
    check_tables(tag);
  endtask

  initial begin
    int u0;
    hv[0] = '{32'h4C54_0010, 1'b0, 1'b1};
    hv[1] = '{32'h4C54_AB10, 1'b0, 1'b1};
    hv[2] = '{32'h4C54_0008, 1'b1, 1'b0};
    hv[3] = '{32'h4C55_0010, 1'b1, 1'b0};
    hv[4] = '{32'h0000_0010, 1'b1, 1'b0};
    hv[5] = '{32'h4C54_0011, 1'b1, 1'b0};

    // reset state and default tables
    reset_dut();
    check("rst_bp0", bp_flat[7:0], 8'd2);
    check("rst_bp15", bp_flat[15*XW +: XW], 8'd32);
    check("rst_k15", k_flat[15*KW +: KW], 32'd16);
    check("rst_upd", tbl_update_p, 1'b0);
    check("rst_err", load_err_p, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready_n", wr_ready_n, 1'b0);
    check_tables("rst");

    // header acceptance table
    for (int i = 0; i < 6; i++) begin
      send_word(hv[i].word);
      check($sformatf("hdr%0d_err", i), load_err_p, hv[i].exp_err);
      check($sformatf("hdr%0d_busy", i), busy, hv[i].exp_busy);
      reset_dut();
    end

    // directed load
    set_payload_t2();
    do_load("t2", 0, 0, -1);
    check("t2_bp0", bp_flat[7:0], 8'hF0);
    check("t2_k3", k_flat[3*KW +: KW], 32'd103);
    check("t2_b5", b_flat[5*BW +: BW], 32'hFFFF_FFFB);

    // non-monotonic breakpoint: bp[5] == bp[4] == 20
    reset_dut();
    set_payload_t2();
    for (int i = 0; i < N; i++) p_bp[i] = (i < 5) ? 4 * (i + 1) : 4 * i;
    do_load("t3", 0, 0, 5);

    // wrong entry count in header, then a good load
    send_word(32'h4C54_0008);
    check("t4_err", load_err_p, 1'b1);
    check("t4_busy", busy, 1'b0);
    gen_payload(1'b0);
    do_load("t4", 0, 0, -1);

    // gapped version of the directed load
    set_payload_t2();
    do_load("t5", 30, 0, -1);
    check("t5_bp0", bp_flat[7:0], 8'hF0);
    check("t5_k3", k_flat[3*KW +: KW], 32'd103);

    // randomized loads, some with an ordering fault
    for (int r = 0; r < 8; r++) begin
      gen_payload($urandom_range(2) == 0);
      do_load($sformatf("rnd%0d", r), int'($urandom_range(40)), 0, bad_j);
    end

    // reset in the middle of a load
    gen_payload(1'b0);
    #1;
    u0 = upd_cnt;
    send_word(HDR);
    for (int w = 0; w < 20; w++) send_word(pword(w));
    check("t6_busy_midload", busy, 1'b1);
    reset_dut();
    check("t6_busy", busy, 1'b0);
    check("t6_ready_n", wr_ready_n, 1'b0);
    check_tables("t6");
    idle(4);
    #1;
    check("t6_no_upd", 32'(upd_cnt - u0), 32'd0);

`ifdef NNLUT_LOAD_CHECKSUM_EN
    gen_payload(1'b0);
    do_load("csum_bad", 0, 1, -1);
    gen_payload(1'b0);
    do_load("csum_good", 0, 0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
